// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional bubble counter output is enabled by defining IDEX_PERF_CNT_EN.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              reg_dst_i,
  input  logic              alu_src_i,
  input  logic              mem_to_reg_i,
  input  logic              reg_write_i,
  input  logic              mem_write_i,
  input  logic              mem_read_i,
  input  logic [1:0]        alu_op_i,
  input  logic              uses_rt_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [5:0]        funct_i,
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [REG_AW-1:0] rt_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  output logic              reg_dst_o,
  output logic              alu_src_o,
  output logic              mem_to_reg_o,
  output logic              reg_write_o,
  output logic              mem_write_o,
  output logic              mem_read_o,
  output logic [1:0]        alu_op_o,
  output logic              uses_rt_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [5:0]        funct_o,
  output logic [REG_AW-1:0] rs_addr_o,
  output logic [REG_AW-1:0] rt_addr_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              valid_o,
  output logic              hazard_stall_o
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [15:0]       bubble_cnt_o
`endif
);

  logic bubble;

  // Flow control: stall_i freezes this stage entirely; otherwise every edge
  // either accepts the ID instruction (valid_o=1) or loads a bubble when
  // flush_i or hazard_stall_o is high. hazard_stall_o tells upstream to hold
  // PC and IF/ID for the same cycle so the dependent instruction is retried.
  assign hazard_stall_o = ~rst_i & valid_o & mem_read_o & (rt_addr_o != '0) &
                          ((rt_addr_o == rs_addr_i) |
                           (uses_rt_i & (rt_addr_o == rt_addr_i)));

  assign bubble = flush_i | hazard_stall_o;

  always_ff @(posedge clk_i) begin
    if (rst_i || (!stall_i && bubble)) begin
      reg_dst_o    <= 1'b0;
      alu_src_o    <= 1'b0;
      mem_to_reg_o <= 1'b0;
      reg_write_o  <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_read_o   <= 1'b0;
      alu_op_o     <= 2'b00;
      uses_rt_o    <= 1'b0;
      pc_o         <= '0;
      rs_data_o    <= '0;
      rt_data_o    <= '0;
      imm_o        <= '0;
      funct_o      <= 6'd0;
      rs_addr_o    <= '0;
      rt_addr_o    <= '0;
      rd_addr_o    <= '0;
      valid_o      <= 1'b0;
    end else if (!stall_i) begin
      reg_dst_o    <= reg_dst_i;
      alu_src_o    <= alu_src_i;
      mem_to_reg_o <= mem_to_reg_i;
      reg_write_o  <= reg_write_i;
      mem_write_o  <= mem_write_i;
      mem_read_o   <= mem_read_i;
      alu_op_o     <= alu_op_i;
      uses_rt_o    <= uses_rt_i;
      pc_o         <= pc_i;
      rs_data_o    <= rs_data_i;
      rt_data_o    <= rt_data_i;
      imm_o        <= imm_i;
      funct_o      <= funct_i;
      rs_addr_o    <= rs_addr_i;
      rt_addr_o    <= rt_addr_i;
      rd_addr_o    <= rd_addr_i;
      valid_o      <= 1'b1;
    end
  end

`ifdef IDEX_PERF_CNT_EN
  // Saturating count of bubbles actually inserted (stalled edges excluded).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubble_cnt_o <= 16'd0;
    end else if (!stall_i && bubble && (bubble_cnt_o != 16'hFFFF)) begin
      bubble_cnt_o <= bubble_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed plan steps followed by randomized traffic,
// all checked against a slot-level reference model of the EX stage.
module tb_id_ex_stage;

  typedef struct packed {
    logic        reg_dst;
    logic        alu_src;
    logic        mem_to_reg;
    logic        reg_write;
    logic        mem_write;
    logic        mem_read;
    logic [1:0]  alu_op;
    logic        uses_rt;
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [5:0]  funct;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
  } id_t;

  logic clk = 1'b0;
  logic rst_i, stall_i, flush_i;
  id_t  id;
  id_t  obs;

  logic        reg_dst_i, alu_src_i, mem_to_reg_i, reg_write_i, mem_write_i, mem_read_i, uses_rt_i;
  logic [1:0]  alu_op_i;
  logic [31:0] pc_i, rs_data_i, rt_data_i, imm_i;
  logic [5:0]  funct_i;
  logic [4:0]  rs_addr_i, rt_addr_i, rd_addr_i;

  logic        reg_dst_o, alu_src_o, mem_to_reg_o, reg_write_o, mem_write_o, mem_read_o, uses_rt_o;
  logic [1:0]  alu_op_o;
  logic [31:0] pc_o, rs_data_o, rt_data_o, imm_o;
  logic [5:0]  funct_o;
  logic [4:0]  rs_addr_o, rt_addr_o, rd_addr_o;
  logic        valid_o, hazard_stall_o;
`ifdef IDEX_PERF_CNT_EN
  logic [15:0] bubble_cnt_o;
`endif

  assign {reg_dst_i, alu_src_i, mem_to_reg_i, reg_write_i, mem_write_i, mem_read_i,
          alu_op_i, uses_rt_i, pc_i, rs_data_i, rt_data_i, imm_i, funct_i,
          rs_addr_i, rt_addr_i, rd_addr_i} = id;
  assign obs = {reg_dst_o, alu_src_o, mem_to_reg_o, reg_write_o, mem_write_o, mem_read_o,
                alu_op_o, uses_rt_o, pc_o, rs_data_o, rt_data_o, imm_o, funct_o,
                rs_addr_o, rt_addr_o, rd_addr_o};

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .reg_dst_i(reg_dst_i), .alu_src_i(alu_src_i), .mem_to_reg_i(mem_to_reg_i),
    .reg_write_i(reg_write_i), .mem_write_i(mem_write_i), .mem_read_i(mem_read_i),
    .alu_op_i(alu_op_i), .uses_rt_i(uses_rt_i), .pc_i(pc_i), .rs_data_i(rs_data_i),
    .rt_data_i(rt_data_i), .imm_i(imm_i), .funct_i(funct_i), .rs_addr_i(rs_addr_i),
    .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
    .reg_dst_o(reg_dst_o), .alu_src_o(alu_src_o), .mem_to_reg_o(mem_to_reg_o),
    .reg_write_o(reg_write_o), .mem_write_o(mem_write_o), .mem_read_o(mem_read_o),
    .alu_op_o(alu_op_o), .uses_rt_o(uses_rt_o), .pc_o(pc_o), .rs_data_o(rs_data_o),
    .rt_data_o(rt_data_o), .imm_o(imm_o), .funct_o(funct_o), .rs_addr_o(rs_addr_o),
    .rt_addr_o(rt_addr_o), .rd_addr_o(rd_addr_o),
    .valid_o(valid_o), .hazard_stall_o(hazard_stall_o)
`ifdef IDEX_PERF_CNT_EN
    , .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model of the EX slot
  id_t         m_ex;
  logic        m_valid;
  logic [15:0] m_cnt;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [191:0] o, input logic [191:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // A load in EX blocks an ID instruction that reads its destination.
  function automatic logic model_haz();
    if (rst_i || !m_valid || !m_ex.mem_read || m_ex.rt_addr == 5'd0) return 1'b0;
    return (m_ex.rt_addr == id.rs_addr) || (id.uses_rt && m_ex.rt_addr == id.rt_addr);
  endfunction

  task automatic check_all();
    #1;
    chk("ex_bundle", 192'(obs), 192'(m_ex));
    chk("valid", 192'(valid_o), 192'(m_valid));
    chk("hazard", 192'(hazard_stall_o), 192'(model_haz()));
`ifdef IDEX_PERF_CNT_EN
    chk("bubble_cnt", 192'(bubble_cnt_o), 192'(m_cnt));
`endif
  endtask

  task automatic tick();
    logic h;
    h = model_haz();
    if (rst_i) begin
      m_ex = '0; m_valid = 1'b0; m_cnt = 16'd0;
    end else if (!stall_i) begin
      if (flush_i || h) begin
        m_ex = '0; m_valid = 1'b0;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else begin
        m_ex = id; m_valid = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // driver helpers
  function automatic id_t rand_id();
    id_t r;
    r.reg_dst    = 1'($urandom);
    r.alu_src    = 1'($urandom);
    r.mem_to_reg = 1'($urandom);
    r.reg_write  = 1'($urandom);
    r.mem_write  = 1'($urandom);
    r.mem_read   = ($urandom_range(0, 2) == 0);
    r.alu_op     = 2'($urandom);
    r.uses_rt    = 1'($urandom);
    r.pc         = $urandom;
    r.rs_data    = $urandom;
    r.rt_data    = $urandom;
    r.imm        = $urandom;
    r.funct      = 6'($urandom);
    r.rs_addr    = 5'($urandom_range(0, 3));
    r.rt_addr    = 5'($urandom_range(0, 3));
    r.rd_addr    = 5'($urandom);
    return r;
  endfunction

  function automatic id_t lw(input logic [4:0] rs, input logic [4:0] rt);
    id_t r = '0;
    r.mem_read = 1'b1; r.mem_to_reg = 1'b1; r.reg_write = 1'b1; r.alu_src = 1'b1;
    r.rs_addr = rs; r.rt_addr = rt; r.imm = 32'h10; r.pc = 32'h100;
    return r;
  endfunction

  function automatic id_t add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_t r = '0;
    r.reg_write = 1'b1; r.reg_dst = 1'b1; r.alu_op = 2'b10; r.uses_rt = 1'b1;
    r.rs_data = 32'h5; r.rt_data = 32'h7; r.funct = 6'h20;
    r.rs_addr = rs; r.rt_addr = rt; r.rd_addr = rd; r.pc = 32'h104;
    return r;
  endfunction

  initial begin
    // reset with every input driven nonzero
    rst_i = 1'b1; stall_i = 1'b1; flush_i = 1'b1;
    id = '1;
    repeat (2) @(posedge clk);
    #1;
    m_ex = '0; m_valid = 1'b0; m_cnt = 16'd0;
    check_all();
    chk("reset_valid", 192'(valid_o), 192'(0));
    chk("reset_hazard", 192'(hazard_stall_o), 192'(0));
    tick();
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;

    // pass-through of an add
    id = add(5'd1, 5'd2, 5'd3);
    check_all();
    tick();
    id = '0;
    check_all();
    chk("pass_valid", 192'(valid_o), 192'(1));
    chk("pass_alu_op", 192'(alu_op_o), 192'(2'b10));
    chk("pass_rs_data", 192'(rs_data_o), 192'(32'h5));
    chk("pass_rt_data", 192'(rt_data_o), 192'(32'h7));

    // load-use: exactly one bubble, then the add enters EX
    id = lw(5'd1, 5'd8);
    tick();
    id = add(5'd8, 5'd2, 5'd9);
    check_all();
    chk("lu_hazard_hi", 192'(hazard_stall_o), 192'(1));
    tick();
    check_all();
    chk("lu_bubble_valid", 192'(valid_o), 192'(0));
    chk("lu_bubble_regw", 192'(reg_write_o), 192'(0));
    chk("lu_hazard_lo", 192'(hazard_stall_o), 192'(0));
    tick();
    check_all();
    chk("lu_add_valid", 192'(valid_o), 192'(1));
    chk("lu_add_rs", 192'(rs_addr_o), 192'(8));

    // register 0 destination and unused rt never stall
    id = lw(5'd1, 5'd0);
    tick();
    id = add(5'd0, 5'd0, 5'd4);
    check_all();
    chk("r0_no_hazard", 192'(hazard_stall_o), 192'(0));
    id = lw(5'd1, 5'd9);
    tick();
    id = add(5'd3, 5'd9, 5'd4);
    id.uses_rt = 1'b0;
    check_all();
    chk("no_use_rt", 192'(hazard_stall_o), 192'(0));

    // back-to-back independent loads
    id = lw(5'd1, 5'd5);
    tick();
    id = lw(5'd2, 5'd6);
    check_all();
    chk("ld_ld_no_stall", 192'(hazard_stall_o), 192'(0));

    // stall beats flush; then flush alone bubbles the store
    id = '0;
    id.mem_write = 1'b1; id.alu_src = 1'b1; id.rs_addr = 5'd2; id.rt_addr = 5'd3; id.imm = 32'h8;
    tick();
    id = rand_id();
    stall_i = 1'b1; flush_i = 1'b1;
    check_all();
    tick();
    check_all();
    chk("stall_hold_mw", 192'(mem_write_o), 192'(1));
    stall_i = 1'b0;
    tick();
    flush_i = 1'b0;
    check_all();
    chk("flush_mw", 192'(mem_write_o), 192'(0));
    chk("flush_valid", 192'(valid_o), 192'(0));

    // flush together with a hazard, then the held instruction loads
    id = lw(5'd1, 5'd4);
    tick();
    id = add(5'd4, 5'd1, 5'd7);
    flush_i = 1'b1;
    check_all();
    tick();
    flush_i = 1'b0;
    check_all();
    tick();
    check_all();

    // reset aborts a pending hazard
    id = lw(5'd1, 5'd8);
    tick();
    id = add(5'd8, 5'd1, 5'd2);
    rst_i = 1'b1;
    check_all();
    chk("rst_kills_hazard", 192'(hazard_stall_o), 192'(0));
    tick();
    rst_i = 1'b0;
    check_all();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      id      = rand_id();
      rst_i   = ($urandom_range(0, 99) == 0);
      stall_i = ($urandom_range(0, 7) == 0);
      flush_i = ($urandom_range(0, 9) == 0);
      check_all();
      tick();
    end
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;

`ifdef IDEX_PERF_CNT_EN
    // 3 flushes + 2 load-use bubbles, then saturation
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    id = '0;
    flush_i = 1'b1;
    repeat (3) tick();
    flush_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      id = lw(5'd1, 5'd8);
      tick();
      id = add(5'd8, 5'd1, 5'd2);
      tick();
      tick();
    end
    check_all();
    chk("cnt_five", 192'(bubble_cnt_o), 192'(16'd5));
    flush_i = 1'b1;
    repeat (65540) tick();
    flush_i = 1'b0;
    check_all();
    chk("cnt_saturate", 192'(bubble_cnt_o), 192'(16'hFFFF));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // overall time bound
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
